// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - shared widths, FSM encoding and per-layer bias constants
package bias_pkg;
    localparam int WD   = 8;
    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int PW   = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Requester order: 0=c1, 1=c3, 2=f5, 3=f6
    localparam logic [AW-1:0] BASE [NREQ] = '{8'd0, 8'd6, 8'd22, 8'd142};
    localparam logic [7:0]    NUM  [NREQ] = '{8'd6, 8'd16, 8'd120, 8'd84};

    function automatic logic [PW-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = PW'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/bias_load_sched_if.sv
// rtl/bias_load_sched_if.sv - request/grant and bias memory/beat bundle
interface bias_load_sched_if;
    import bias_pkg::*;

    logic [NREQ-1:0] i_req;
    logic [NREQ-1:0] o_gnt;
    logic [NREQ-1:0] o_done;
    logic            o_busy;
    logic            o_mem_rd;
    logic [AW-1:0]   o_mem_addr;
    logic [WD-1:0]   i_mem_data;
    logic            o_b_en;
    logic [7:0]      o_b_num;
    logic [WD-1:0]   o_bias;

    modport slave (
        input  i_req, i_mem_data,
        output o_gnt, o_done, o_busy, o_mem_rd, o_mem_addr, o_b_en, o_b_num, o_bias
    );

    modport master (
        output i_req, i_mem_data,
        input  o_gnt, o_done, o_busy, o_mem_rd, o_mem_addr, o_b_en, o_b_num, o_bias
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker searching upward from p_i
module rr_arbiter
    import bias_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   p_i,
    output logic [NREQ-1:0] gnt_o
);
    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(p_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bias_load_sched.sv
// rtl/bias_load_sched.sv - arbitrates per-layer bias loads and streams the words out
module bias_load_sched
    import bias_pkg::*;
(
    input  logic               i_sclk,
    input  logic               i_rstn,
    bias_load_sched_if.slave   bus
);
    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   k_q, k_d;
    logic [PW-1:0]   p_q, p_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            b_en_q, b_en_d;
    logic [7:0]      b_num_q, b_num_d;
    logic [NREQ-1:0] arb_gnt;
    logic            mem_rd;

    rr_arbiter u_arb (
        .req_i (bus.i_req),
        .p_i   (p_q),
        .gnt_o (arb_gnt)
    );

    assign mem_rd = (state_q == S_READ);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.i_req) begin
                    state_d = S_READ;
                    gnt_d   = arb_gnt;
                    k_d     = oh_to_idx(arb_gnt);
                    p_d     = (k_d == PW'(NREQ - 1)) ? '0 : k_d + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                // cnt_q is the offset of the address being read this cycle
                if (cnt_q == NUM[k_q] - 8'd1) state_d = S_DRAIN;
                else                          cnt_d   = cnt_q + 8'd1;
            end
            S_DRAIN: state_d = S_DONE;
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Beat outputs trail the read strobe by one cycle to line up with memory latency
    assign b_en_d  = mem_rd;
    assign b_num_d = mem_rd ? cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge i_sclk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            b_en_q  <= 1'b0;
            b_num_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            b_en_q  <= b_en_d;
            b_num_q <= b_num_d;
        end
    end

    always_comb begin
        bus.o_gnt      = gnt_q;
        bus.o_done     = (state_q == S_DONE) ? gnt_q : '0;
        bus.o_busy     = (state_q != S_IDLE);
        bus.o_mem_rd   = mem_rd;
        bus.o_mem_addr = mem_rd ? BASE[k_q] + AW'(cnt_q) : '0;
        bus.o_b_en     = b_en_q;
        bus.o_b_num    = b_num_q;
        bus.o_bias     = b_en_q ? bus.i_mem_data : '0;
    end
endmodule

// File: doc/bias_load_sched.md
BIAS_LOAD_SCHED -- requirements
Module: bias_load_sched

Interface
REQ-001 Parameters SHALL be: WD 8, bias word width; NREQ 4, number of requesters (0=c1, 1=c3, 2=f5, 3=f6); AW 8, bias memory address width.
REQ-002 Clock SHALL be i_sclk, a single clock; reset SHALL be i_rstn, synchronous, active-low.
REQ-003 Ports SHALL be:
- i_sclk  in  1  clock
- i_rstn  in  1  sync active-low reset
- i_req  in  NREQ  per-layer bias load request, level
- o_gnt  out  NREQ  one-hot grant, held for the whole burst
- o_done  out  NREQ  one-hot one-cycle completion pulse
- o_busy  out  1  high when state is not IDLE
- o_mem_rd  out  1  bias memory read strobe
- o_mem_addr  out  AW  bias memory read address
- i_mem_data  in  WD  read data, valid exactly 1 cycle after o_mem_rd
- o_b_en  out  1  bias beat valid
- o_b_num  out  8  1-based index of the current beat within the layer
- o_bias  out  WD  bias word

Function
REQ-004 The FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-005 In IDLE with i_req nonzero at edge T, the FSM SHALL select one requester k round-robin and enter READ at T+1 with o_gnt[k]=1.
REQ-006 Round-robin SHALL search upward from pointer p with wrap-around; after a grant to k, p SHALL become (k+1) mod NREQ.
REQ-007 READ SHALL last NUM[k] cycles, driving o_mem_rd=1 with o_mem_addr = BASE[k], BASE[k]+1, ..., BASE[k]+NUM[k]-1 on consecutive cycles, with no gaps.
REQ-008 o_b_en SHALL be high for exactly NUM[k] consecutive cycles, starting 1 cycle after the first o_mem_rd, with o_bias=i_mem_data and o_b_num=1..NUM[k].
REQ-009 After the last READ cycle the FSM SHALL spend 1 cycle in DRAIN, in which the last beat is output, and then 1 cycle in DONE.
REQ-010 In DONE, o_done[k] SHALL pulse for 1 cycle; o_gnt SHALL remain high through DONE and clear on entry to IDLE.
REQ-011 Arbitration SHALL occur only in IDLE; i_req sampled in READ, DRAIN or DONE SHALL be ignored.
REQ-012 A requester SHALL drop i_req in its o_done cycle; i_req still high in the following IDLE cycle SHALL count as a new request.
REQ-013 Deassertion of i_req[k] mid-burst SHALL NOT abort the burst.
REQ-014 At most one bit of o_gnt and of o_done SHALL be high in any cycle.
REQ-015 o_mem_addr SHALL equal 0 and o_b_num SHALL equal 0 whenever their strobes are low.
REQ-016 Back-to-back bursts SHALL be separated by exactly one IDLE cycle.
REQ-017 o_b_num SHALL be 8 bits wide, and NUM[k] SHALL be at most 255.

Reset
REQ-018 With i_rstn=0 at an edge, the FSM SHALL go to IDLE, p SHALL be 0, and o_gnt, o_done, o_busy, o_mem_rd, o_mem_addr, o_b_en, o_b_num and o_bias SHALL all be 0 from the next cycle.
REQ-019 A reset in the middle of a burst SHALL abandon the burst without an o_done pulse.
REQ-020 The first request serviced after reset SHALL be serviced from a fresh start.

Structure
REQ-021 Package bias_pkg SHALL hold WD, AW, NREQ, the state encoding, and the per-layer constants:
- BASE = {0, 6, 22, 142}
- NUM = {6, 16, 120, 84}
REQ-022 The round-robin picker SHALL be a sub-module rr_arbiter (inputs: req, p; output: one-hot grant), combinational; the registered state SHALL stay in bias_load_sched.
REQ-023 The beat counter and the address counter SHALL be shared by all requesters and indexed by k.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single c1 request at T -> o_gnt=0001 at T+1; addr 0..5 at T+1..T+6; o_b_num 1..6 at T+2..T+7; o_done=0001 at T+8.
- f5 request only -> 120 beats, addr 22..141, o_b_num ends at 120, o_done=0100.
- i_req=1111 held (each bit dropped on its own o_done and re-raised) -> grant order 0,1,2,3,0, with exactly one IDLE cycle between bursts.
- i_req[3] dropped in the middle of an f6 burst -> all 84 beats still delivered, then o_done=1000.
- i_rstn=0 at beat 50 of f5 -> all outputs 0 the next cycle, no o_done; the next request is granted to requester 0 if it is pending.
- i_mem_data = address + 3 -> o_bias matches address + 3 on every beat; no beat is dropped or duplicated.
